// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential shift-add-3 (double-dabble) binary-to-BCD converter.
// It watches bin_in and reconverts whenever the value differs from the last one
// converted. bcd_out/ndigits hold the last complete result and update only on the
// done pulse.
// Optional feature macro: BIN_TO_BCD_SIGNED_EN. When it is defined, bin_in is two's
// complement, the magnitude is converted and neg gives the sign. When it is not
// defined, bin_in is unsigned and neg is tied to 0.
module bin_to_bcd_seq #(
   parameter int W      = 16,
   parameter int DIGITS = 5
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [W-1:0]                    bin_in,
   output logic [4*DIGITS-1:0]             bcd_out,
   output logic [$clog2(DIGITS+1)-1:0]     ndigits,
   output logic                            neg,
   output logic                            busy,
   output logic                            done
);

   localparam int BW  = 4 * DIGITS;
   localparam int NDW = $clog2(DIGITS + 1);
   localparam int CW  = $clog2(W + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

   // True when DIGITS decimal digits can hold every W-bit value.
   function automatic bit range_ok();
      logic [127:0] p10;
      p10 = 128'd1;
      for (int i = 0; i < DIGITS; i++) p10 = p10 * 128'd10;
      return p10 > (128'd1 << W);
   endfunction

   if (!range_ok()) begin : g_range_chk
      $error("bin_to_bcd_seq: DIGITS too small for W (need 10^DIGITS > 2^W)");
   end

   // One double-dabble step: add 3 to every digit >= 5, then shift in the new bit.
   // Top bit falling out of the scratch is never significant given range_ok().
   function automatic logic [BW-1:0] shift_add3(input logic [BW-1:0] s, input logic b);
      logic [BW-1:0] t;
      t = s;
      for (int i = 0; i < DIGITS; i++) begin
         if (t[4*i +: 4] >= 4'd5) t[4*i +: 4] = t[4*i +: 4] + 4'd3;
      end
      return {t[BW-2:0], b};
   endfunction

   // Index of the highest nonzero digit plus one; 1 for an all-zero value.
   function automatic logic [NDW-1:0] sig_digits(input logic [BW-1:0] s);
      logic [NDW-1:0] n;
      n = NDW'(1);
      for (int i = 0; i < DIGITS; i++) begin
         if (s[4*i +: 4] != 4'd0) n = NDW'(i + 1);
      end
      return n;
   endfunction

   state_t           r_state;
   logic [W-1:0]     r_last;
   logic [W-1:0]     r_op;
   logic [BW-1:0]    r_scr;
   logic [CW-1:0]    r_cnt;
   logic [BW-1:0]    r_bcd;
   logic [NDW-1:0]   r_nd;
   logic             r_busy;
   logic             r_done;
   logic             w_start;
   logic [W-1:0]     w_operand;

   assign w_start = (r_state == ST_IDLE) && (bin_in != r_last);

`ifdef BIN_TO_BCD_SIGNED_EN
   logic             r_neg;
   logic             r_neg_cap;
   // Magnitude as W-bit unsigned, so the most negative value maps to 2^(W-1).
   assign w_operand = bin_in[W-1] ? ({W{1'b0}} - bin_in) : bin_in;
   assign neg       = r_neg;
`else
   assign w_operand = bin_in;
   assign neg       = 1'b0;
`endif

   // Control FSM and registered outputs; reset aborts any conversion in progress.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_last  <= '0;
         r_cnt   <= '0;
         r_bcd   <= '0;
         r_nd    <= NDW'(1);
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
`ifdef BIN_TO_BCD_SIGNED_EN
         r_neg   <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_start) begin
                  r_last  <= bin_in;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               r_cnt <= r_cnt + CW'(1);
               if (r_cnt == CW'(W - 1)) r_state <= ST_DONE;
            end
            ST_DONE: begin
               r_bcd   <= r_scr;
               r_nd    <= sig_digits(r_scr);
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
`ifdef BIN_TO_BCD_SIGNED_EN
               r_neg   <= r_neg_cap;
`endif
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Datapath: operand capture and the shift-add-3 scratch; no reset needed since
   // the FSM decides when these values are meaningful.
   always_ff @(posedge clk) begin
      if (w_start) begin
         r_op  <= w_operand;
         r_scr <= '0;
`ifdef BIN_TO_BCD_SIGNED_EN
         r_neg_cap <= bin_in[W-1];
`endif
      end else if (r_state == ST_SHIFT) begin
         r_scr <= shift_add3(r_scr, r_op[W-1]);
         r_op  <= {r_op[W-2:0], 1'b0};
      end
   end

   assign bcd_out = r_bcd;
   assign ndigits = r_nd;
   assign busy    = r_busy;
   assign done    = r_done;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Testbench for bin_to_bcd_seq (W=16, DIGITS=5): directed vectors, a scoreboard
// queue filled by the stimulus and drained by a monitor on each done pulse.
module tb_bin_to_bcd_seq;

   localparam int W      = 16;
   localparam int DIGITS = 5;

   typedef struct packed {
      logic [19:0] bcd;
      logic [2:0]  nd;
      logic        ng;
   } exp_t;

   logic          clk;
   logic          reset;
   logic [W-1:0]  bin_in;
   logic [19:0]   bcd_out;
   logic [2:0]    ndigits;
   logic          neg;
   logic          busy;
   logic          done;

   int   n_checks = 0;
   int   n_pass   = 0;
   exp_t sb_q[$];

   bin_to_bcd_seq #(.W(W), .DIGITS(DIGITS)) dut (
      .clk     (clk),
      .reset   (reset),
      .bin_in  (bin_in),
      .bcd_out (bcd_out),
      .ndigits (ndigits),
      .neg     (neg),
      .busy    (busy),
      .done    (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!reset && done === 1'b1) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_done", {12'd0, bcd_out}, 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("sb_bcd", {12'd0, bcd_out}, {12'd0, e.bcd});
            chk("sb_nd", {29'd0, ndigits}, {29'd0, e.nd});
            chk("sb_neg", {31'd0, neg}, {31'd0, e.ng});
            chk("sb_busy_low", {31'd0, busy}, 32'd0);
         end
      end
   end

   // Counts posedges until done is seen (bounded); edges=0 means it timed out.
   task automatic wait_done(output int edges);
      edges = 0;
      for (int i = 1; i <= 60; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1) begin
            edges = i;
            break;
         end
      end
      if (edges == 0) chk("done_timeout", 32'd0, 32'd1);
   endtask

   // Presents a value, checks busy after the capture edge and the done latency.
   task automatic convert(input logic [W-1:0] v, input logic [19:0] eb,
                          input logic [2:0] en, input logic eg, input string name);
      int e;
      exp_t x;
      @(negedge clk);
      bin_in = v;
      x.bcd = eb; x.nd = en; x.ng = eg;
      sb_q.push_back(x);
      @(posedge clk); #1;
      chk({name, "_busy"}, {31'd0, busy}, 32'd1);
      wait_done(e);
      chk({name, "_lat"}, e, 32'd17);
   endtask

   initial begin
      int e;
      int ndone;
      int nbusy;
      exp_t x;

      reset  = 1'b1;
      bin_in = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_bcd", {12'd0, bcd_out}, 32'd0);
      chk("rst_nd", {29'd0, ndigits}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_neg", {31'd0, neg}, 32'd0);
      reset = 1'b0;

      // Idle with bin_in equal to the reset value: nothing happens.
      ndone = 0; nbusy = 0;
      repeat (50) begin
         @(posedge clk); #1;
         if (done) ndone++;
         if (busy) nbusy++;
      end
      chk("idle_done_cnt", ndone, 32'd0);
      chk("idle_busy_cnt", nbusy, 32'd0);

      convert(16'd1234, 20'h01234, 3'd4, 1'b0, "c1234");
`ifdef BIN_TO_BCD_SIGNED_EN
      convert(16'hFFFF, 20'h00001, 3'd1, 1'b1, "cFFFF");
`else
      convert(16'd65535, 20'h65535, 3'd5, 1'b0, "c65535");
`endif

      // Changes during SHIFT are ignored; only the final value converts next.
      @(negedge clk);
      bin_in = 16'd9;
      x.bcd = 20'h00009; x.nd = 3'd1; x.ng = 1'b0;
      sb_q.push_back(x);
      @(posedge clk);
      repeat (3) @(posedge clk);
      #1 bin_in = 16'd10;
      repeat (3) @(posedge clk);
      #1 bin_in = 16'd11;
      x.bcd = 20'h00011; x.nd = 3'd2; x.ng = 1'b0;
      sb_q.push_back(x);
      wait_done(e);
      wait_done(e);
      chk("burst_second_lat", e, 32'd18);
      repeat (40) @(posedge clk);
      chk("burst_q_empty", sb_q.size(), 32'd0);

      // Reset five cycles into a conversion, bin_in held.
      @(negedge clk);
      bin_in = 16'd500;
      @(posedge clk);
      repeat (5) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      chk("abort_bcd", {12'd0, bcd_out}, 32'd0);
      chk("abort_nd", {29'd0, ndigits}, 32'd1);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      reset = 1'b0;
      x.bcd = 20'h00500; x.nd = 3'd3; x.ng = 1'b0;
      sb_q.push_back(x);
      @(posedge clk); #1;
      chk("reconv_busy", {31'd0, busy}, 32'd1);
      wait_done(e);
      chk("reconv_lat", e, 32'd17);

      convert(16'd10, 20'h00010, 3'd2, 1'b0, "c10");
      convert(16'd0, 20'h00000, 3'd1, 1'b0, "c0");
`ifdef BIN_TO_BCD_SIGNED_EN
      convert(16'h8000, 20'h32768, 3'd5, 1'b1, "c8000");
      convert(16'd0, 20'h00000, 3'd1, 1'b0, "cneg0");
`else
      convert(16'd32768, 20'h32768, 3'd5, 1'b0, "c32768");
`endif

      repeat (30) @(posedge clk);
      chk("final_q_empty", sb_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
